lfsr8_gen: RTL and testbench
============================

// Module: lfsr8_gen
// PURPOSE
//  8-bit maximal-length Fibonacci LFSR pseudo-random sequence generator.
//  Loads a user seed, then advances one state per clock while enabled.
//  Flags each return to the seed (period 255).
//  Used as a test-pattern / scrambler source on a single clock domain.
// PARAMETERS
//  none. Width 8 and taps are fixed. Polynomial x^8+x^6+x^5+x^4+1.
// PORTS
//  clk_i       in   1  system clock, all logic on rising edge
//  rst_i       in   1  synchronous active-low reset
//  val         in   8  seed, sampled only on a load cycle
//  start_i     in   1  run enable: load on first high cycle, then step
//  result      out  8  current LFSR state (registered)
//  wrap_o      out  1  1-cycle pulse when a step returns the state to the seed
//  step_cnt_o  out  8  steps since load, range 0..254
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low.
//  - Reset (rst_i==0 at a clk edge):
//    - result=0, seed=0, step_cnt_o=0, wrap_o=0, loaded=0.
//    - Reset has priority over everything, including mid-run.
//  - Internal registers:
//    - state[7:0], which drives result.
//    - seed[7:0].
//    - loaded flag.
//  - States:
//    - IDLE (loaded=0).
//    - RUN (loaded=1).
//  - IDLE, start_i=1 (load cycle):
//    - state<=val, seed<=val, step_cnt_o<=0, loaded<=1.
//    - Latency: result==val on the same edge; no step happens on the load edge.
//  - IDLE, start_i=0: all registers hold.
//  - RUN, start_i=1 (step), Fibonacci left shift:
//    - fb = s[7]^s[5]^s[4]^s[3].
//    - state <= {s[6:0], fb}.
//  - RUN, start_i=0 (pause):
//    - state holds; loaded<=0 (go to IDLE).
//    - step_cnt_o holds.
//    - The next start_i=1 reloads from val (no resume).
//  - Step counter: step_cnt_o increments on each step.
//  - Wrap (next state == seed on a step):
//    - wrap_o<=1 for exactly one cycle; otherwise wrap_o<=0.
//    - step_cnt_o<=0.
//  - Period: 255 steps for any nonzero seed, so result==seed every 255 steps.
//  - val changes while in RUN are ignored.
//  - Zero seed: see CONFIGURATION.
// CONFIGURATION
//  Macro LFSR8_GEN_LOCKUP_GUARD_EN.
//  - Defined:
//    - A load with val==0 stores 8'h01 into both state and seed.
//    - In RUN, if state is ever 0 it is forced to 8'h01 on the next step.
//  - Undefined:
//    - A zero seed loads 0 and the state stays 0.
//    - wrap_o pulses on every step.
//    - step_cnt_o stays 0.
// TESTING
//  1. Reset: rst_i=0 for 1 edge with start_i=1 -> result=0, wrap_o=0, step_cnt_o=0.
//  2. Load then step, seed 0xAA, start_i=1:
//     - Edge 1: result=0xAA.
//     - Edge 2: result=0x55.
//     - Edge 3: result=0xAB.
//  3. Full period, seed 0xAA, start held:
//     - Exactly 255 steps after the load, result==0xAA and wrap_o=1 that cycle.
//     - No earlier repeat of 0xAA.
//     - step_cnt_o=0 after the wrap.
//  4. Pause and reload:
//     - After 10 steps, drop start_i for 2 cycles -> result holds.
//     - Set val=0x3C and raise start_i -> result=0x3C.
//  5. Reset mid-run: assert rst_i=0 during stepping -> next edge result=0, IDLE.
//  6. Zero seed, val=0:
//     - Guard defined -> result=0x01, then 0x02.
//     - Guard undefined -> result stays 0.

Source files
------------

// File: rtl/lfsr8_gen.sv
// rtl/lfsr8_gen.sv - 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with seed load, wrap flag and step counter
// Optional zero-seed lockup guard: LFSR8_GEN_LOCKUP_GUARD_EN
module lfsr8_gen (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] val,
  input  logic       start_i,
  output logic [7:0] result,
  output logic       wrap_o,
  output logic [7:0] step_cnt_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] fsm_q,   fsm_d;
  logic [7:0] state_q, state_d;
  logic [7:0] seed_q,  seed_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       wrap_q,  wrap_d;

  logic       fb;
  logic [7:0] step_nxt;
  logic [7:0] load_val;

  assign fb = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];

`ifdef LFSR8_GEN_LOCKUP_GUARD_EN
  // All-zero is the one state the shifter can never leave, so steer around it.
  assign load_val = (val == 8'h00) ? 8'h01 : val;
  assign step_nxt = (state_q == 8'h00) ? 8'h01 : {state_q[6:0], fb};
`else
  assign load_val = val;
  assign step_nxt = {state_q[6:0], fb};
`endif

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (fsm_q == ST_IDLE) begin
      if (start_i) begin
        state_d = load_val;
        seed_d  = load_val;
        cnt_d   = 8'h00;
        fsm_d   = ST_RUN;
      end
    end else begin
      if (start_i) begin
        state_d = step_nxt;
        if (step_nxt == seed_q) begin
          wrap_d = 1'b1;
          cnt_d  = 8'h00;
        end else begin
          cnt_d  = cnt_q + 8'd1;
        end
      end else begin
        // Dropping start abandons the run; the next start reloads from val.
        fsm_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fsm_q   <= ST_IDLE;
      state_q <= 8'h00;
      seed_q  <= 8'h00;
      cnt_q   <= 8'h00;
      wrap_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign result     = state_q;
  assign wrap_o     = wrap_q;
  assign step_cnt_o = cnt_q;

endmodule

// File: tb/tb_lfsr8_gen.sv
// tb/tb_lfsr8_gen.sv - directed self-checking bench for lfsr8_gen
module tb_lfsr8_gen;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] val;
  logic       start_i;
  logic [7:0] result;
  logic       wrap_o;
  logic [7:0] step_cnt_o;

  int total = 0;
  int bad   = 0;

  lfsr8_gen dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .val        (val),
    .start_i    (start_i),
    .result     (result),
    .wrap_o     (wrap_o),
    .step_cnt_o (step_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  initial begin
    logic [7:0] m;
    logic [7:0] mcnt;
    int         early;
    int         track;

    // reset with start high
    rst_i = 1'b0; start_i = 1'b1; val = 8'h5A;
    tick();
    chk("rst_result", result, 8'h00);
    chk("rst_wrap", wrap_o, 1'b0);
    chk("rst_cnt", step_cnt_o, 8'h00);

    // load 0xAA and first two steps
    rst_i = 1'b1; val = 8'hAA;
    tick();
    chk("load_aa", result, 8'hAA);
    chk("load_cnt", step_cnt_o, 8'h00);
    val = 8'h11;
    tick();
    chk("step1", result, 8'h55);
    chk("step1_cnt", step_cnt_o, 8'h01);
    tick();
    chk("step2", result, 8'hAB);
    chk("step2_cnt", step_cnt_o, 8'h02);

    // remainder of the period
    m = 8'hAB; mcnt = 8'd2; early = 0; track = 0;
    for (int i = 3; i <= 255; i++) begin
      tick();
      m = nxt(m);
      mcnt = (i == 255) ? 8'd0 : mcnt + 8'd1;
      if (result !== m || step_cnt_o !== mcnt) track++;
      if (i < 255 && (result == 8'hAA || wrap_o)) early++;
      if (i == 254) chk("cnt_254", step_cnt_o, 8'd254);
    end
    chk("period_track", track, 0);
    chk("no_early_repeat", early, 0);
    chk("wrap_result", result, 8'hAA);
    chk("wrap_pulse", wrap_o, 1'b1);
    chk("wrap_cnt", step_cnt_o, 8'h00);
    tick();
    chk("post_wrap_result", result, 8'h55);
    chk("post_wrap_pulse", wrap_o, 1'b0);
    chk("post_wrap_cnt", step_cnt_o, 8'h01);

    // nine more steps (10 since wrap) then pause
    m = 8'h55;
    for (int i = 0; i < 9; i++) begin
      tick();
      m = nxt(m);
    end
    chk("pre_pause", result, m);
    chk("pre_pause_cnt", step_cnt_o, 8'd10);
    start_i = 1'b0;
    tick();
    chk("pause1", result, m);
    chk("pause1_wrap", wrap_o, 1'b0);
    val = 8'h3C;
    tick();
    chk("pause2", result, m);
    chk("pause2_cnt", step_cnt_o, 8'd10);
    start_i = 1'b1;
    tick();
    chk("reload_3c", result, 8'h3C);
    chk("reload_cnt", step_cnt_o, 8'h00);
    tick();
    chk("step_3c", result, 8'h79);
    chk("step_3c_cnt", step_cnt_o, 8'h01);

    // reset mid-run, then start must load rather than step
    rst_i = 1'b0;
    tick();
    chk("midrst_result", result, 8'h00);
    chk("midrst_cnt", step_cnt_o, 8'h00);
    chk("midrst_wrap", wrap_o, 1'b0);
    rst_i = 1'b1; val = 8'hC3;
    tick();
    chk("after_rst_load", result, 8'hC3);

    // zero seed
    start_i = 1'b0;
    tick();
    val = 8'h00; start_i = 1'b1;
    tick();
`ifdef LFSR8_GEN_LOCKUP_GUARD_EN
    chk("zero_load", result, 8'h01);
    tick();
    chk("zero_step", result, 8'h02);
    chk("zero_wrap", wrap_o, 1'b0);
    chk("zero_cnt", step_cnt_o, 8'h01);
`else
    chk("zero_load", result, 8'h00);
    tick();
    chk("zero_step", result, 8'h00);
    chk("zero_wrap", wrap_o, 1'b1);
    chk("zero_cnt", step_cnt_o, 8'h00);
    tick();
    chk("zero_step2", result, 8'h00);
    chk("zero_wrap2", wrap_o, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
